// File: rtl/hamming_encode_engine.sv
// rtl/hamming_encode_engine.sv - SECDED Hamming encoder acting as an alternate data-memory master
module hamming_encode_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          go,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic          busy,
    output logic          halt,
    output logic [3:0]    msg_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [11:1]   d;
    logic          p8, p4, p2, p1, p0;
    logic [15:0]   cw;
    logic [AW-1:0] idx_x2;
    logic          last_msg;
    logic          wr_req;

    // Byte offset of the current message; wraps with the address width.
    assign idx_x2   = AW'({msg_idx, 1'b0});
    assign last_msg = (msg_idx == 4'(NUM_MSG - 1));

    // State, message index and latched message bits.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= S_IDLE;
            msg_idx <= '0;
            d       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE: if (go) msg_idx <= '0;
                S_RD_LO:        d[8:1]  <= mem_rd_data;
                S_RD_HI:        d[11:9] <= mem_rd_data[2:0];
                S_WR_HI:        if (!last_msg) msg_idx <= msg_idx + 4'd1;
                default:        ;
            endcase
        end
    end

    // Parity bits and codeword assembly from the latched message.
    always_comb begin
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        cw = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    end

    // Next-state decode and memory-port drive.
    always_comb begin
        state_nxt   = state;
        mem_addr    = '0;
        mem_wr_data = '0;
        wr_req      = 1'b0;
        busy        = 1'b0;
        halt        = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) state_nxt = S_RD_LO;
            end
            S_RD_LO: begin
                busy      = 1'b1;
                mem_addr  = AW'(SRC_BASE) + idx_x2;
                state_nxt = S_RD_HI;
            end
            S_RD_HI: begin
                busy      = 1'b1;
                mem_addr  = AW'(SRC_BASE) + idx_x2 + AW'(1);
                state_nxt = S_WR_LO;
            end
            S_WR_LO: begin
                busy        = 1'b1;
                mem_addr    = AW'(DST_BASE) + idx_x2;
                wr_req      = 1'b1;
                mem_wr_data = cw[7:0];
                state_nxt   = S_WR_HI;
            end
            S_WR_HI: begin
                busy        = 1'b1;
                mem_addr    = AW'(DST_BASE) + idx_x2 + AW'(1);
                wr_req      = 1'b1;
                mem_wr_data = cw[15:8];
                state_nxt   = last_msg ? S_DONE : S_RD_LO;
            end
            S_DONE: begin
                halt = 1'b1;
                if (go) state_nxt = S_RD_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset kills the strobe in the cycle it is sampled so no write lands at that edge.
    assign mem_wr_en = wr_req & ~Reset;

endmodule

// File: tb/tb_hamming_encode_engine.sv
// tb/tb_hamming_encode_engine.sv - scoreboard bench for hamming_encode_engine
module tb_hamming_encode_engine;

    localparam int NUM_MSG  = 15;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 30;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       go = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic       busy;
    logic       halt;
    logic [3:0] msg_idx;

    logic [7:0]  mem [0:255];
    logic [7:0]  snap [0:255];
    logic [15:0] sb [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    hamming_encode_engine #(
        .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .AW(8)
    ) dut (
        .CLK(CLK), .Reset(Reset), .go(go),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .busy(busy), .halt(halt), .msg_idx(msg_idx)
    );

    always #5 CLK = ~CLK;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge CLK) begin
        if (mem_wr_en === 1'b1) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference encoder: classic Hamming(15,11) positions, overall parity in bit 0.
    function automatic logic [15:0] encode(input logic [10:0] m);
        logic [15:0] c;
        logic        x;
        int          k;
        c = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int pos = 1; pos < 16; pos++) if ((pos & p) != 0) x ^= c[pos];
            c[p] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Every write is popped against the scoreboard at the falling edge.
    always @(negedge CLK) begin
        logic [15:0] e;
        if (mem_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                check("wr_data", {24'd0, mem_wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    function automatic logic [10:0] msg_of(input int i);
        logic [7:0] hi;
        hi = mem[SRC_BASE + 2 * i + 1];
        return {hi[2:0], mem[SRC_BASE + 2 * i]};
    endfunction

    task automatic push_msg(input int i, input bit hi_too);
        logic [15:0] c;
        c = encode(msg_of(i));
        sb.push_back({8'(DST_BASE + 2 * i), c[7:0]});
        if (hi_too) sb.push_back({8'(DST_BASE + 2 * i + 1), c[15:8]});
    endtask

    task automatic pulse_go();
        @(posedge CLK); #1 go = 1'b1;
        @(posedge CLK); #1 go = 1'b0;
    endtask

    // One full run; mid_go >= 0 pulses go that many cycles into the run.
    task automatic run(input string tag, input int mid_go);
        int         n;
        int         mono_bad;
        logic [3:0] prev;
        for (int i = 0; i < NUM_MSG; i++) push_msg(i, 1'b1);
        pulse_go();
        check({tag, "_busy_after_go"}, {31'd0, busy}, 32'd1);
        check({tag, "_halt_after_go"}, {31'd0, halt}, 32'd0);
        n = 0;
        mono_bad = 0;
        prev = msg_idx;
        while (halt !== 1'b1 && n < 200) begin
            if (n == mid_go) go = 1'b1;
            @(posedge CLK); #1 go = 1'b0;
            n++;
            if (msg_idx < prev) mono_bad++;
            prev = msg_idx;
        end
        check({tag, "_cycles_to_halt"}, n, 32'd60);
        check({tag, "_msg_idx_monotonic"}, mono_bad, 32'd0);
        check({tag, "_sb_drained"}, sb.size(), 32'd0);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        sb.delete();
    endtask

    task automatic fill_random(input bit garbage);
        for (int i = 0; i < NUM_MSG; i++) begin
            mem[SRC_BASE + 2 * i]     = 8'($urandom);
            mem[SRC_BASE + 2 * i + 1] = garbage ? 8'($urandom) : 8'($urandom_range(0, 7));
        end
    endtask

    initial begin
        int         n;
        logic [15:0] w;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        // Reset holds everything idle even with go asserted.
        go = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_msg_idx", {28'd0, msg_idx}, 32'd0);
        go = 1'b0;
        Reset = 1'b0;

        // T1: all-zero messages.
        for (int a = DST_BASE; a < DST_BASE + 30; a++) mem[a] = 8'h5A;
        run("t1", -1);
        for (int a = DST_BASE; a < DST_BASE + 30; a++) check("t1_dst_zero", {24'd0, mem[a]}, 32'd0);

        // T2 / T3: directed corner messages.
        mem[0] = 8'hFF; mem[1] = 8'h07;
        mem[2] = 8'h01; mem[3] = 8'h00;
        mem[4] = 8'h00; mem[5] = 8'h04;
        run("t23", -1);
        check("t2_lo", {24'd0, mem[30]}, 32'hFF);
        check("t2_hi", {24'd0, mem[31]}, 32'hFF);
        check("t3a_lo", {24'd0, mem[32]}, 32'h0F);
        check("t3a_hi", {24'd0, mem[33]}, 32'h00);
        check("t3b_lo", {24'd0, mem[34]}, 32'h17);
        check("t3b_hi", {24'd0, mem[35]}, 32'h81);

        // T4: random messages with garbage in the ignored high bits.
        fill_random(1'b1);
        for (int a = 0; a < 30; a++) snap[a] = mem[a];
        run("t4", -1);
        for (int i = 0; i < NUM_MSG; i++) begin
            w = {mem[DST_BASE + 2 * i + 1], mem[DST_BASE + 2 * i]};
            check("t4_even_parity", $countones(w) % 2, 32'd0);
        end
        for (int a = 0; a < 30; a++) check("t4_src_untouched", {24'd0, mem[a]}, {24'd0, snap[a]});

        // T5: Reset asserted during WR_HI of message 5.
        fill_random(1'b0);
        for (int a = DST_BASE; a < DST_BASE + 30; a++) mem[a] = 8'hA5;
        for (int i = 0; i < 5; i++) push_msg(i, 1'b1);
        push_msg(5, 1'b0);
        pulse_go();
        n = 0;
        while (!(mem_wr_en === 1'b1 && mem_addr === 8'(DST_BASE + 11)) && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("t5_reached_wr_hi5", {31'd0, n < 100}, 32'd1);
        Reset = 1'b1;
        #1;
        check("t5_wr_en_same_cycle", {31'd0, mem_wr_en}, 32'd0);
        @(posedge CLK); #1 Reset = 1'b0;
        #1;
        check("t5_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_halt", {31'd0, halt}, 32'd0);
        check("t5_msg_idx", {28'd0, msg_idx}, 32'd0);
        check("t5_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("t5_sb_drained", sb.size(), 32'd0);
        check("t5_hi5_untouched", {24'd0, mem[DST_BASE + 11]}, 32'hA5);
        check("t5_lo6_untouched", {24'd0, mem[DST_BASE + 12]}, 32'hA5);
        sb.delete();
        repeat (5) @(posedge CLK);
        #1;
        check("t5_stays_idle", {31'd0, busy}, 32'd0);

        // T6: go while busy is ignored; go in DONE reruns with identical output.
        fill_random(1'b1);
        run("t6a", 20);
        check("t6_halt_held", {31'd0, halt}, 32'd1);
        for (int a = DST_BASE; a < DST_BASE + 30; a++) snap[a] = mem[a];
        run("t6b", 0);
        for (int a = DST_BASE; a < DST_BASE + 30; a++)
            check("t6_rerun_identical", {24'd0, mem[a]}, {24'd0, snap[a]});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
